// File: rtl/i2c_reg_seq.sv
// ---------------------------------------------------------------------------
// i2c_reg_seq
//
// Purpose:
//   Register-access sequencer placed directly upstream of the I2C master.
//   It turns one register command into the master's transaction handshake
//   and returns one response per command.
//   - A write is a single 2-byte transaction: register address, then data.
//   - A read is a 1-byte pointer write followed by a 1-byte read
//     transaction.
//   After the last byte of each transaction the sequencer idles for
//   GAP_CYCLES cycles so the master can finish its ack and stop.
//
// Parameters:
//   GAP_CYCLES      idle cycles after the last byte handshake of a transaction
//   TIMEOUT_CYCLES  maximum wait for a master byte handshake (timeout build only)
//
// Ports:
//   clock, reset         system clock; asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_rd, cmd_dev, cmd_reg, cmd_wdata)
//   rsp_valid/rsp_ready  response handshake (rsp_data, rsp_err)
//   addr, lenMsg, rdWr,
//   startTxRx            master transaction request
//   inData/inValid/inReady     TX byte stream to the master
//   outData/outValid/outReady  RX byte stream from the master
//
// Configuration macro:
//   I2C_REG_SEQ_TIMEOUT_EN  compiles in the handshake timeout and rsp_err.
//   Without it, handshake states wait forever and rsp_err is tied to 0.
// ---------------------------------------------------------------------------
module i2c_reg_seq #(
    parameter int GAP_CYCLES     = 12288,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [6:0] addr,
    output logic [7:0] lenMsg,
    output logic       rdWr,
    output logic       startTxRx,
    output logic [7:0] inData,
    output logic       inValid,
    input  logic       inReady,
    input  logic [7:0] outData,
    input  logic       outValid,
    output logic       outReady
);

    localparam int MAX_CYCLES = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
`ifdef I2C_REG_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE, START, TX_REG, TX_DATA, GAP, RD_START, RX, RSP
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          is_read, is_read_next;
    logic [7:0]    reg_addr, reg_next;
    logic [7:0]    wr_data, wr_data_next;
    logic          rd_phase, rd_phase_next;

    logic [6:0]    addr_next;
    logic [7:0]    len_next;
    logic          rdwr_next;
    logic [7:0]    in_data_next;
    logic [7:0]    rsp_data_next;
    logic          cmd_ready_next;
    logic          rsp_valid_next;
    logic          start_next;
    logic          in_valid_next;
    logic          out_ready_next;
`ifdef I2C_REG_SEQ_TIMEOUT_EN
    logic          err_next;
`endif

    // All outputs are registered. The next-state logic below computes the
    // value each output must show while the FSM sits in state_next, so every
    // output changes on the same edge as the state it belongs to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            is_read   <= 1'b0;
            reg_addr  <= '0;
            wr_data   <= '0;
            rd_phase  <= 1'b0;
            addr      <= '0;
            lenMsg    <= '0;
            rdWr      <= 1'b0;
            inData    <= '0;
            rsp_data  <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            startTxRx <= 1'b0;
            inValid   <= 1'b0;
            outReady  <= 1'b0;
`ifdef I2C_REG_SEQ_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            is_read   <= is_read_next;
            reg_addr  <= reg_next;
            wr_data   <= wr_data_next;
            rd_phase  <= rd_phase_next;
            addr      <= addr_next;
            lenMsg    <= len_next;
            rdWr      <= rdwr_next;
            inData    <= in_data_next;
            rsp_data  <= rsp_data_next;
            cmd_ready <= cmd_ready_next;
            rsp_valid <= rsp_valid_next;
            startTxRx <= start_next;
            inValid   <= in_valid_next;
            outReady  <= out_ready_next;
`ifdef I2C_REG_SEQ_TIMEOUT_EN
            rsp_err   <= err_next;
`endif
        end
    end

`ifndef I2C_REG_SEQ_TIMEOUT_EN
    assign rsp_err = 1'b0;
`endif

    // Next-state and next-output logic. addr/lenMsg/rdWr are only rewritten
    // when entering START or RD_START so they stay stable across the whole
    // transaction; inData is only rewritten when a new byte is presented.
    always_comb begin
        state_next    = state;
        is_read_next  = is_read;
        reg_next      = reg_addr;
        wr_data_next  = wr_data;
        rd_phase_next = rd_phase;
        addr_next     = addr;
        len_next      = lenMsg;
        rdwr_next     = rdWr;
        in_data_next  = inData;
        rsp_data_next = rsp_data;
`ifdef I2C_REG_SEQ_TIMEOUT_EN
        err_next      = rsp_err;
`endif

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    is_read_next  = cmd_rd;
                    reg_next      = cmd_reg;
                    wr_data_next  = cmd_wdata;
                    rd_phase_next = 1'b0;
                    rsp_data_next = 8'h00;
`ifdef I2C_REG_SEQ_TIMEOUT_EN
                    err_next      = 1'b0;
`endif
                    addr_next     = cmd_dev;
                    len_next      = cmd_rd ? 8'd1 : 8'd2;
                    rdwr_next     = 1'b0;
                    state_next    = START;
                end
            end
            START: begin
                in_data_next = reg_addr;
                state_next   = TX_REG;
            end
            TX_REG: begin
                if (inValid && inReady) begin
                    if (is_read) begin
                        rd_phase_next = 1'b1;
                        state_next    = GAP;
                    end else begin
                        in_data_next = wr_data;
                        state_next   = TX_DATA;
                    end
                end
            end
            TX_DATA: begin
                if (inValid && inReady) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    if (rd_phase && !rsp_err) begin
                        rd_phase_next = 1'b0;
                        len_next      = 8'd1;
                        rdwr_next     = 1'b1;
                        state_next    = RD_START;
                    end else begin
                        state_next = RSP;
                    end
                end
            end
            RD_START: begin
                state_next = RX;
            end
            RX: begin
                if (outValid && outReady) begin
                    rsp_data_next = outData;
                    state_next    = GAP;
                end
            end
            RSP: begin
                if (rsp_valid && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef I2C_REG_SEQ_TIMEOUT_EN
        // Expiry only applies when no handshake happened this cycle, so a
        // handshake landing on the last allowed cycle still wins. The GAP
        // that follows lets the master complete its stop before responding.
        if ((state == TX_REG || state == TX_DATA || state == RX) &&
            state_next == state && cnt == TIMEOUT_LAST) begin
            err_next      = 1'b1;
            rsp_data_next = 8'h00;
            state_next    = GAP;
        end
`endif

        // One shared counter: it restarts on every state change and only
        // advances in states that measure time, so it never wraps.
        cnt_next = cnt;
        if (state_next != state) begin
            cnt_next = '0;
        end else if (state == GAP
`ifdef I2C_REG_SEQ_TIMEOUT_EN
                     || state == TX_REG || state == TX_DATA || state == RX
`endif
                    ) begin
            cnt_next = cnt + CW'(1);
        end

        cmd_ready_next = (state_next == IDLE);
        rsp_valid_next = (state_next == RSP);
        start_next     = (state_next == START) || (state_next == RD_START);
        in_valid_next  = (state_next == TX_REG) || (state_next == TX_DATA);
        out_ready_next = (state_next == RX);
    end

endmodule

// File: doc/i2c_reg_seq.md
# i2c_reg_seq

Register-access sequencer sitting directly upstream of the I2C master. It turns one register command (device address, register address, write data or read request) into the master's transaction handshake: `addr`/`lenMsg`/`rdWr`/`startTxRx`, TX bytes on `inData`/`inValid`/`inReady`, and RX bytes on `outData`/`outValid`/`outReady`. It returns one response per command, carrying read data and an error flag.

## Interface
- `GAP_CYCLES`, default 12288: idle cycles after the last byte handshake, covering ack and stop, before the transaction counts as finished.
- `TIMEOUT_CYCLES`, default 65536: maximum wait for any master byte handshake.
- `clock` in 1: system clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_rd` in 1: 1 = register read, 0 = register write.
- `cmd_dev` in 7: 7-bit device address.
- `cmd_reg` in 8: register address.
- `cmd_wdata` in 8: write data; ignored for reads.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_data` out 8: read data; 0x00 for writes and on error.
- `rsp_err` out 1: the command timed out.
- `addr` out 7, `lenMsg` out 8, `rdWr` out 1, `startTxRx` out 1: master transaction request.
- `inData` out 8, `inValid` out 1, `inReady` in 1: TX byte stream to the master.
- `outData` in 8, `outValid` in 1, `outReady` out 1: RX byte stream from the master.

## Operation
- FSM states: IDLE, START, TX_REG, TX_DATA, GAP, RD_START, RX, RSP.
- IDLE: `cmd_ready`=1. On `cmd_valid`&`cmd_ready`, latch all `cmd_*` fields, clear the error flag, go to START.
- START (1 cycle): `startTxRx`=1, `addr`=dev, `rdWr`=0.
  - `lenMsg`=2 for a write, 1 for a read (register-pointer write).
  - Go to TX_REG.
- TX_REG: `inValid`=1, `inData`=reg.
  - On `inValid`&`inReady`: write goes to TX_DATA; read goes to GAP with the read-phase flag set.
- TX_DATA: `inValid`=1, `inData`=wdata. On handshake, go to GAP.
- GAP: count `GAP_CYCLES` cycles, then:
  - read-phase flag set and no error: go to RD_START;
  - otherwise: go to RSP.
- RD_START (1 cycle): `startTxRx`=1, `rdWr`=1, `lenMsg`=1. Clear the read-phase flag, go to RX.
- RX: `outReady`=1. On `outValid`&`outReady`, capture `outData` into `rsp_data`, go to GAP.
- RSP: `rsp_valid`=1 until `rsp_ready`, then go to IDLE.
- Timeout, with the feature compiled in:
  - a counter clears on entry to TX_REG, TX_DATA and RX, and increments each cycle spent in those states;
  - on reaching `TIMEOUT_CYCLES-1`, set `rsp_err`, force `rsp_data`=0x00, go to GAP (lets the master finish its stop), then go to RSP and skip any read phase.
- `addr`, `lenMsg` and `rdWr` hold stable from START until the next START. `inData` holds while `inValid`=1.
- Counter widths are `$clog2` of the larger of the two parameters. There is no wrap-around: each counter clears on every state entry.

## Timing
- Reset (asynchronous, active-low): state IDLE; every output 0, including `cmd_ready`.
  - `cmd_ready` is registered and rises on the first clock edge after reset deasserts.
- Accept at edge N: `cmd_ready` low at N+1; `startTxRx` pulse for exactly cycle N+1; `inValid` from N+2.
- Byte handshake on `inReady` at edge M:
  - next byte presented at M+1;
  - after the last byte, `inValid` is low from M+1.
- Write response latency: last TX handshake + `GAP_CYCLES` + 1 cycles until `rsp_valid`.
- `rsp_valid` and `rsp_data` hold stable until accepted. `cmd_ready` reasserts the cycle after the RSP handshake; `cmd_valid` is ignored at all other times.
- Simultaneous `inReady`/`outValid` with the timeout-expiry cycle: the handshake wins and no error is set.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The in-flight command is dropped with no response.

## Configuration
- `I2C_REG_SEQ_TIMEOUT_EN` defined: the timeout counter and `rsp_err` logic are compiled in.
- Not defined:
  - the timeout counter and `rsp_err` logic are compiled out;
  - handshake states wait indefinitely;
  - `rsp_err` is tied to 0;
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- Write: dev 0x10, reg 0x4A, data 0x5C; master model accepts each byte after 2 cycles -> one `startTxRx` pulse with `addr`=0x10, `lenMsg`=2, `rdWr`=0; bytes 0x4A then 0x5C; after `GAP_CYCLES`, `rsp_valid` with `rsp_err`=0 and `rsp_data`=0x00.
- Read: dev 0x10, reg 0x03; model returns 0xA5 -> first transaction `lenMsg`=1, `rdWr`=0, byte 0x03; after GAP, second `startTxRx` with `rdWr`=1, `lenMsg`=1; `rsp_data`=0xA5, `rsp_err`=0.
- No-ack, with `TIMEOUT_CYCLES`=256: `inReady` never asserted -> after 256 cycles in TX_REG, `inValid` drops; after GAP, `rsp_err`=1 and `rsp_data`=0x00; no read phase.
- Backpressure: `rsp_ready` low for 100 cycles -> response stable throughout; `cmd_ready`=0; a pulsed `cmd_valid` is ignored.
- Reset during TX_DATA -> all outputs 0 asynchronously; `cmd_ready`=1 one cycle after release; the next write completes normally.
- Back-to-back: write then read issued with `cmd_valid` held high -> second command accepted the cycle after the first RSP handshake; both responses correct.
